ctrl_decode_pipe: RTL and testbench

//  Registered MIPS control-decode stage between IF/ID and EX. Decodes instr into a control bundle, holds it in
//  an ID/EX register with valid/ready handshake, and inserts bubbles for load-use hazards and busy MULT/DIV.

---
 rtl/ctrl_decode_pipe.sv | 252 +++++++++++++++++++++++++
 tb/tb_ctrl_decode_pipe.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_decode_pipe.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module     : ctrl_decode_pipe
// Description: MIPS control decode with ID/EX register, load-use and MDU interlocks
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
module ctrl_decode_pipe #(
    parameter int ALUOP_W    = 4,
    parameter int LU_BUBBLES = 1,
    parameter int MDU_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [31:0]        id_instr,
    output logic               id_ready,
    input  logic               flush,
    input  logic               ex_ready,
    output logic               ex_valid,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic [11:0]        ex_ctrl,
    output logic [4:0]         ex_rd,
    output logic               mdu_busy
);

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_BLEZ  = 6'h06;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_ADDIU = 6'h09;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SH    = 6'h29;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [5:0] c_FN_SLL     = 6'h00;
    localparam logic [5:0] c_FN_SRL     = 6'h02;
    localparam logic [5:0] c_FN_SRA     = 6'h03;
    localparam logic [5:0] c_FN_SRLV    = 6'h06;
    localparam logic [5:0] c_FN_JR      = 6'h08;
    localparam logic [5:0] c_FN_SYSCALL = 6'h0C;
    localparam logic [5:0] c_FN_MFHI    = 6'h10;
    localparam logic [5:0] c_FN_MFLO    = 6'h12;
    localparam logic [5:0] c_FN_MULT    = 6'h18;
    localparam logic [5:0] c_FN_MULTU   = 6'h19;
    localparam logic [5:0] c_FN_DIV     = 6'h1A;
    localparam logic [5:0] c_FN_DIVU    = 6'h1B;
    localparam logic [5:0] c_FN_ADD     = 6'h20;
    localparam logic [5:0] c_FN_ADDU    = 6'h21;
    localparam logic [5:0] c_FN_SUB     = 6'h22;
    localparam logic [5:0] c_FN_AND     = 6'h24;
    localparam logic [5:0] c_FN_OR      = 6'h25;
    localparam logic [5:0] c_FN_NOR     = 6'h27;
    localparam logic [5:0] c_FN_SLT     = 6'h2A;
    localparam logic [5:0] c_FN_SLTU    = 6'h2B;

    localparam logic [3:0] c_ALU_SLL  = 4'b0000;
    localparam logic [3:0] c_ALU_SRA  = 4'b0001;
    localparam logic [3:0] c_ALU_SRL  = 4'b0010;
    localparam logic [3:0] c_ALU_ADD  = 4'b0101;
    localparam logic [3:0] c_ALU_SUB  = 4'b0110;
    localparam logic [3:0] c_ALU_AND  = 4'b0111;
    localparam logic [3:0] c_ALU_OR   = 4'b1000;
    localparam logic [3:0] c_ALU_NOR  = 4'b1010;
    localparam logic [3:0] c_ALU_SLT  = 4'b1011;
    localparam logic [3:0] c_ALU_SLTU = 4'b1100;

    localparam logic [1:0]       c_LU_BUB   = 2'(LU_BUBBLES);
    localparam logic [CNT_W-1:0] c_MDU_LOAD = CNT_W'(MDU_CYCLES - 1);

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [4:0] w_rdf;

    logic [3:0] w_alu4;
    logic       w_reg_dst, w_reg_we, w_mem_we, w_mem_to_reg, w_alu_src, w_branch;
    logic       w_branch_eq, w_jump, w_jump_reg, w_jal, w_usign, w_shift;
    logic       w_reads_rt;
    logic [4:0] w_dest;

    logic       w_is_muldiv, w_is_mfhilo;
    logic       w_ex_free, w_lu_hazard, w_mdu_hazard, w_hazard, w_accept;
    logic [1:0] w_bub_eff;

    logic                r_ex_valid;
    logic [ALUOP_W-1:0]  r_ex_aluop;
    logic [11:0]         r_ex_ctrl;
    logic [4:0]          r_ex_rd;
    logic [1:0]          r_bub;
    logic [CNT_W-1:0]    r_mdu;

    assign w_op    = id_instr[31:26];
    assign w_rs    = id_instr[25:21];
    assign w_rt    = id_instr[20:16];
    assign w_rdf   = id_instr[15:11];
    assign w_funct = id_instr[5:0];

    always_comb begin
        w_alu4       = c_ALU_ADD;
        w_reg_dst    = 1'b0;
        w_reg_we     = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_to_reg = 1'b0;
        w_alu_src    = 1'b0;
        w_branch     = 1'b0;
        w_branch_eq  = 1'b0;
        w_jump       = 1'b0;
        w_jump_reg   = 1'b0;
        w_jal        = 1'b0;
        w_usign      = 1'b0;
        w_shift      = 1'b0;
        w_reads_rt   = 1'b0;
        // The all-zero word is the canonical NOP, not a real sll
        if (id_instr != 32'h0) begin
            case (w_op)
                c_OP_RTYPE: begin
                    w_reads_rt = 1'b1;
                    w_reg_dst  = 1'b1;
                    w_reg_we   = 1'b1;
                    case (w_funct)
                        c_FN_SLL:  begin w_alu4 = c_ALU_SLL; w_shift = 1'b1; end
                        c_FN_SRA:  begin w_alu4 = c_ALU_SRA; w_shift = 1'b1; end
                        c_FN_SRL,
                        c_FN_SRLV: begin w_alu4 = c_ALU_SRL; w_shift = 1'b1; end
                        c_FN_ADD:  ;
                        c_FN_ADDU: w_usign = 1'b1;
                        c_FN_SUB:  w_alu4 = c_ALU_SUB;
                        c_FN_AND:  w_alu4 = c_ALU_AND;
                        c_FN_OR:   w_alu4 = c_ALU_OR;
                        c_FN_NOR:  w_alu4 = c_ALU_NOR;
                        c_FN_SLT:  w_alu4 = c_ALU_SLT;
                        c_FN_SLTU: w_alu4 = c_ALU_SLTU;
                        c_FN_MFHI,
                        c_FN_MFLO: ;
                        c_FN_JR: begin
                            w_reg_we   = 1'b0;
                            w_jump     = 1'b1;
                            w_jump_reg = 1'b1;
                        end
                        c_FN_SYSCALL, c_FN_MULT, c_FN_MULTU, c_FN_DIV, c_FN_DIVU:
                            w_reg_we = 1'b0;
                        default: begin
                            w_reg_dst = 1'b0;
                            w_reg_we  = 1'b0;
                        end
                    endcase
                end
                c_OP_ADDI:  begin w_reg_we = 1'b1; w_alu_src = 1'b1; end
                c_OP_ADDIU: begin w_reg_we = 1'b1; w_alu_src = 1'b1; w_usign = 1'b1; end
                c_OP_SLTI:  begin w_reg_we = 1'b1; w_alu_src = 1'b1; w_alu4 = c_ALU_SLT; end
                c_OP_ANDI:  begin w_reg_we = 1'b1; w_alu_src = 1'b1; w_alu4 = c_ALU_AND; end
                c_OP_ORI:   begin w_reg_we = 1'b1; w_alu_src = 1'b1; w_alu4 = c_ALU_OR; end
                c_OP_LW: begin
                    w_reg_we     = 1'b1;
                    w_mem_to_reg = 1'b1;
                    w_alu_src    = 1'b1;
                end
                c_OP_SW, c_OP_SH: begin
                    w_mem_we   = 1'b1;
                    w_alu_src  = 1'b1;
                    w_reads_rt = 1'b1;
                end
                c_OP_BEQ: begin
                    w_branch    = 1'b1;
                    w_branch_eq = 1'b1;
                    w_reads_rt  = 1'b1;
                end
                c_OP_BNE: begin
                    w_branch   = 1'b1;
                    w_reads_rt = 1'b1;
                end
                c_OP_BLEZ: begin
                    w_reg_we  = 1'b1;
                    w_alu_src = 1'b1;
                    w_branch  = 1'b1;
                end
                c_OP_J:   begin w_alu_src = 1'b1; w_jump = 1'b1; end
                c_OP_JAL: begin w_reg_we = 1'b1; w_alu_src = 1'b1; w_jump = 1'b1; w_jal = 1'b1; end
                default: ;
            endcase
        end
    end

    assign w_dest = w_jal ? 5'd31 : (w_reg_dst ? w_rdf : w_rt);

    assign w_is_muldiv = (w_op == c_OP_RTYPE) && (w_funct[5:2] == 4'b0110);
    assign w_is_mfhilo = (w_op == c_OP_RTYPE) &&
                         ((w_funct == c_FN_MFHI) || (w_funct == c_FN_MFLO));

    // r_ex_ctrl[8] is mem_to_reg of the instruction currently in EX
    assign w_lu_hazard  = id_valid && r_ex_valid && r_ex_ctrl[8] && (r_ex_rd != 5'd0) &&
                          ((r_ex_rd == w_rs) || (w_reads_rt && (r_ex_rd == w_rt)));
    assign w_mdu_hazard = id_valid && (r_mdu != '0) && (w_is_muldiv || w_is_mfhilo);
    assign w_bub_eff    = (r_bub != 2'd0) ? r_bub : (w_lu_hazard ? c_LU_BUB : 2'd0);
    assign w_hazard     = (r_bub != 2'd0) || w_lu_hazard || w_mdu_hazard;
    assign w_ex_free    = !r_ex_valid || ex_ready;
    assign id_ready     = w_ex_free && !w_hazard;
    assign w_accept     = id_valid && id_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid <= 1'b0;
            r_ex_aluop <= '0;
            r_ex_ctrl  <= '0;
            r_ex_rd    <= '0;
            r_bub      <= 2'd0;
            r_mdu      <= '0;
        end else begin
            // The acceptance cycle counts as the first busy cycle
            if (w_accept && w_is_muldiv) begin
                r_mdu <= c_MDU_LOAD;
            end else if (r_mdu != '0) begin
                r_mdu <= r_mdu - 1'b1;
            end

            if (flush) begin
                r_ex_valid <= 1'b0;
                r_bub      <= 2'd0;
            end else if (w_ex_free) begin
                if (w_bub_eff != 2'd0) begin
                    r_ex_valid <= 1'b0;
                    r_bub      <= w_bub_eff - 2'd1;
                end else if (w_accept) begin
                    r_ex_valid <= 1'b1;
                    r_ex_aluop <= ALUOP_W'(w_alu4);
                    r_ex_ctrl  <= {w_reg_dst, w_reg_we, w_mem_we, w_mem_to_reg, w_alu_src,
                                   w_branch, w_branch_eq, w_jump, w_jump_reg, w_jal,
                                   w_usign, w_shift};
                    r_ex_rd    <= w_dest;
                end else begin
                    r_ex_valid <= 1'b0;
                end
            end
        end
    end

    assign ex_valid = r_ex_valid;
    assign ex_aluop = r_ex_aluop;
    assign ex_ctrl  = r_ex_ctrl;
    assign ex_rd    = r_ex_rd;
    assign mdu_busy = (r_mdu != '0);

endmodule
`default_nettype wire

// File: tb/tb_ctrl_decode_pipe.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module     : tb_ctrl_decode_pipe
// Description: Directed decode table plus hazard, flush and reset sequences
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_ctrl_decode_pipe;

    localparam logic [31:0] c_LW   = 32'h8C220000;  // lw   $2,0($1)
    localparam logic [31:0] c_ADD  = 32'h00441820;  // add  $3,$2,$4
    localparam logic [31:0] c_ADD2 = 32'h00221820;  // add  $3,$1,$2
    localparam logic [31:0] c_SUB  = 32'h00C72822;  // sub  $5,$6,$7
    localparam logic [31:0] c_MULT = 32'h00220018;  // mult $1,$2
    localparam logic [31:0] c_MFLO = 32'h00002812;  // mflo $5

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        id_ready;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [3:0]  ex_aluop;
    logic [11:0] ex_ctrl;
    logic [4:0]  ex_rd;
    logic        mdu_busy;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  aluop;
        logic [11:0] ctrl;
        logic [4:0]  rd;
    } vec_t;

    vec_t vecs[16];

    ctrl_decode_pipe #(
        .ALUOP_W   (4),
        .LU_BUBBLES(1),
        .MDU_CYCLES(4),
        .CNT_W     (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .id_valid(id_valid),
        .id_instr(id_instr),
        .id_ready(id_ready),
        .flush   (flush),
        .ex_ready(ex_ready),
        .ex_valid(ex_valid),
        .ex_aluop(ex_aluop),
        .ex_ctrl (ex_ctrl),
        .ex_rd   (ex_rd),
        .mdu_busy(mdu_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{32'h00221820, 4'b0101, 12'hC00, 5'd3};   // add
        vecs[1]  = '{32'hAC220004, 4'b0101, 12'h280, 5'd2};   // sw
        vecs[2]  = '{32'hFC430000, 4'b0101, 12'h000, 5'd3};   // undefined op
        vecs[3]  = '{32'h00C72822, 4'b0110, 12'hC00, 5'd5};   // sub
        vecs[4]  = '{32'h2528FFFF, 4'b0101, 12'h482, 5'd8};   // addiu
        vecs[5]  = '{32'h8D6A0000, 4'b0101, 12'h580, 5'd10};  // lw
        vecs[6]  = '{32'h10220010, 4'b0101, 12'h060, 5'd2};   // beq
        vecs[7]  = '{32'h0C000100, 4'b0101, 12'h494, 5'd31};  // jal
        vecs[8]  = '{32'h03E00008, 4'b0101, 12'h818, 5'd0};   // jr
        vecs[9]  = '{32'h00052080, 4'b0000, 12'hC01, 5'd4};   // sll
        vecs[10] = '{32'h34E600FF, 4'b1000, 12'h480, 5'd6};   // ori
        vecs[11] = '{32'h0043082A, 4'b1011, 12'hC00, 5'd1};   // slt
        vecs[12] = '{32'h014B4827, 4'b1010, 12'hC00, 5'd9};   // nor
        vecs[13] = '{32'h00000000, 4'b0101, 12'h000, 5'd0};   // nop
        vecs[14] = '{32'h0064103F, 4'b0101, 12'h000, 5'd4};   // undefined funct
        vecs[15] = '{32'h30220003, 4'b0111, 12'h480, 5'd2};   // andi

        rst      = 1'b1;
        id_valid = 1'b0;
        id_instr = 32'h0;
        flush    = 1'b0;
        ex_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_ex_aluop", 32'(ex_aluop), 32'd0);
        chk("rst_ex_ctrl",  32'(ex_ctrl),  32'd0);
        chk("rst_ex_rd",    32'(ex_rd),    32'd0);
        chk("rst_mdu_busy", 32'(mdu_busy), 32'd0);
        chk("rst_id_ready", 32'(id_ready), 32'd1);

        // Decode table: one instruction at a time with an idle cycle between
        for (int i = 0; i < 16; i++) begin
            step();
            id_valid = 1'b1;
            id_instr = vecs[i].instr;
            @(negedge clk);
            for (int t = 0; t < 8 && !id_ready; t++) @(negedge clk);
            chk($sformatf("tbl%0d_ready", i), 32'(id_ready), 32'd1);
            step();
            id_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), 32'(ex_valid), 32'd1);
            chk($sformatf("tbl%0d_aluop", i), 32'(ex_aluop), 32'(vecs[i].aluop));
            chk($sformatf("tbl%0d_ctrl", i),  32'(ex_ctrl),  32'(vecs[i].ctrl));
            chk($sformatf("tbl%0d_rd", i),    32'(ex_rd),    32'(vecs[i].rd));
        end
        step();

        // Load-use: one stall cycle, one bubble, then the add issues
        step(); id_valid = 1'b1; id_instr = c_LW;
        @(negedge clk); chk("lu_lw_ready", 32'(id_ready), 32'd1);
        step(); id_instr = c_ADD;
        @(negedge clk);
        chk("lu_stall_ready", 32'(id_ready), 32'd0);
        chk("lu_ex_lw_ctrl",  32'(ex_ctrl),  32'h580);
        step();
        @(negedge clk);
        chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
        chk("lu_resume_ready", 32'(id_ready), 32'd1);
        step(); id_valid = 1'b0;
        @(negedge clk);
        chk("lu_add_valid", 32'(ex_valid), 32'd1);
        chk("lu_add_rd",    32'(ex_rd),    32'd3);
        chk("lu_add_ctrl",  32'(ex_ctrl),  32'hC00);
        step();

        // MDU: mflo held for three cycles, accepted on the fourth
        step(); id_valid = 1'b1; id_instr = c_MULT;
        @(negedge clk); chk("mdu_mult_ready", 32'(id_ready), 32'd1);
        step(); id_instr = c_MFLO;
        @(negedge clk);
        chk("mdu_ex_mult_ctrl", 32'(ex_ctrl), 32'h800);
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) begin
                step();
                @(negedge clk);
            end
            chk($sformatf("mdu_hold%0d_ready", k), 32'(id_ready), 32'd0);
            chk($sformatf("mdu_hold%0d_busy", k),  32'(mdu_busy), 32'd1);
        end
        step();
        @(negedge clk);
        chk("mdu_release_ready", 32'(id_ready), 32'd1);
        chk("mdu_release_busy",  32'(mdu_busy), 32'd0);
        step(); id_valid = 1'b0;
        @(negedge clk);
        chk("mdu_mflo_valid", 32'(ex_valid), 32'd1);
        chk("mdu_mflo_rd",    32'(ex_rd),    32'd5);
        chk("mdu_mflo_ctrl",  32'(ex_ctrl),  32'hC00);
        step();

        // Backpressure: EX stalls three cycles, bundle frozen, sub not lost
        step(); id_valid = 1'b1; id_instr = c_ADD2;
        @(negedge clk); chk("bp_add_ready", 32'(id_ready), 32'd1);
        step(); ex_ready = 1'b0; id_instr = c_SUB;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_valid", k), 32'(ex_valid), 32'd1);
            chk($sformatf("bp%0d_rd", k),    32'(ex_rd),    32'd3);
            chk($sformatf("bp%0d_aluop", k), 32'(ex_aluop), 32'b0101);
            chk($sformatf("bp%0d_ready", k), 32'(id_ready), 32'd0);
            step();
        end
        ex_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(id_ready), 32'd1);
        chk("bp_release_rd",    32'(ex_rd),    32'd3);
        step(); id_valid = 1'b0;
        @(negedge clk);
        chk("bp_sub_valid", 32'(ex_valid), 32'd1);
        chk("bp_sub_rd",    32'(ex_rd),    32'd5);
        chk("bp_sub_aluop", 32'(ex_aluop), 32'b0110);
        step();

        // Flush with lw in EX (stalled) and dependent add at ID
        step(); id_valid = 1'b1; id_instr = c_LW;
        @(negedge clk); chk("fl_lw_ready", 32'(id_ready), 32'd1);
        step(); id_instr = c_ADD; flush = 1'b1; ex_ready = 1'b0;
        @(negedge clk); chk("fl_stall_ready", 32'(id_ready), 32'd0);
        step(); flush = 1'b0; ex_ready = 1'b1;
        @(negedge clk);
        chk("fl_ex_valid", 32'(ex_valid), 32'd0);
        chk("fl_no_bubble_ready", 32'(id_ready), 32'd1);
        step(); id_valid = 1'b0;
        @(negedge clk);
        chk("fl_add_valid", 32'(ex_valid), 32'd1);
        chk("fl_add_rd",    32'(ex_rd),    32'd3);
        step();

        // Asynchronous reset mid-stream with EX holding and MDU busy
        step(); id_valid = 1'b1; id_instr = c_MULT;
        step(); id_instr = c_MFLO; ex_ready = 1'b0;
        @(negedge clk);
        chk("ar_pre_busy",  32'(mdu_busy), 32'd1);
        chk("ar_pre_valid", 32'(ex_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_ex_valid", 32'(ex_valid), 32'd0);
        chk("ar_mdu_busy", 32'(mdu_busy), 32'd0);
        chk("ar_id_ready", 32'(id_ready), 32'd1);
        chk("ar_ex_ctrl",  32'(ex_ctrl),  32'd0);
        chk("ar_ex_aluop", 32'(ex_aluop), 32'd0);
        chk("ar_ex_rd",    32'(ex_rd),    32'd0);
        id_valid = 1'b0;
        ex_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
